mem_io_sequencer: RTL and testbench

- Owns the single SRAM port and the memory-mapped switch/hex I/O of the SLC-3 top level.
- Sequences timed SRAM read/write cycles for two requesters: the CPU (MAR/MDR path, MIO_EN) and the memory-init loader.
- Returns the CPU "R" ready pulse.
- Decodes address xFFFF as I/O: switches on read, hex display register on write.

---
 rtl/slc3_pkg.sv | 19 +
 rtl/mem_io_sequencer_if.sv | 50 +++++
 rtl/mem_io_sequencer.sv | 146 ++++++++++++++
 tb/tb_mem_io_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// Shared SLC-3 types: sequencer state encoding, requester grant and the I/O address.
package slc3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE,
        IO
    } seq_state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_INIT
    } grant_t;

    localparam logic [15:0] IO_ADDR = 16'hFFFF;

endpackage

// File: rtl/mem_io_sequencer_if.sv
// Bundle of CPU, loader, SRAM and board I/O signals around the memory sequencer.
interface mem_io_sequencer_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;

    logic        init_req;
    logic [15:0] init_addr;
    logic [15:0] init_wdata;
    logic        init_ack;

    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic        mem_we_n;

    logic [9:0]  sw_in;
    logic [15:0] hex_out;

    // Sequencer side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  init_req, init_addr, init_wdata,
        output init_ack,
        output mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n,
        input  mem_rdata,
        input  sw_in,
        output hex_out
    );

    // Requester / board side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output init_req, init_addr, init_wdata,
        input  init_ack,
        input  mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n,
        output mem_rdata,
        output sw_in,
        input  hex_out
    );

endinterface

// File: rtl/mem_io_sequencer.sv
// Arbitrates CPU and loader onto the single SRAM port with timed strobes, and decodes
// the memory-mapped switch/hex register. All outputs are registered from next-state.
module mem_io_sequencer
    import slc3_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = slc3_pkg::IO_ADDR
) (
    input  logic               Clk,
    input  logic               Reset,
    mem_io_sequencer_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    seq_state_t  state_q, state_d;
    grant_t      gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] hex_q, hex_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        init_ack_q, init_ack_d;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        cpu_rdata_d = cpu_rdata_q;
        hex_d       = hex_q;
        cpu_ready_d = 1'b0;
        init_ack_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The loader wins ties and never decodes I/O.
                if (bus.init_req) begin
                    gnt_d       = GNT_INIT;
                    we_d        = 1'b1;
                    mem_addr_d  = bus.init_addr;
                    mem_wdata_d = bus.init_wdata;
                    cnt_d       = CNT_LOAD;
                    ce_n_d      = 1'b0;
                    state_d     = SETUP;
                end else if (bus.cpu_req) begin
                    gnt_d = GNT_CPU;
                    we_d  = bus.cpu_we;
                    if (bus.cpu_addr == IO_ADDR) begin
                        state_d     = IO;
                        cpu_ready_d = 1'b1;
                        if (bus.cpu_we) begin
                            hex_d = bus.cpu_wdata;
                        end else begin
                            cpu_rdata_d = {6'b0, bus.sw_in};
                        end
                    end else begin
                        mem_addr_d  = bus.cpu_addr;
                        mem_wdata_d = bus.cpu_wdata;
                        cnt_d       = CNT_LOAD;
                        ce_n_d      = 1'b0;
                        oe_n_d      = bus.cpu_we;
                        state_d     = SETUP;
                    end
                end
            end
            SETUP: begin
                ce_n_d  = 1'b0;
                oe_n_d  = we_q;
                we_n_d  = ~we_q;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d     = DONE;
                    cpu_ready_d = (gnt_q == GNT_CPU);
                    init_ack_d  = (gnt_q == GNT_INIT);
                    if (!we_q) begin
                        cpu_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    ce_n_d = 1'b0;
                    oe_n_d = we_q;
                    we_n_d = ~we_q;
                end
            end
            DONE:    state_d = IDLE;
            IO:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_CPU;
            we_q        <= 1'b0;
            cnt_q       <= 4'd0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            cpu_rdata_q <= 16'h0000;
            hex_q       <= 16'h0000;
            cpu_ready_q <= 1'b0;
            init_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            cpu_rdata_q <= cpu_rdata_d;
            hex_q       <= hex_d;
            cpu_ready_q <= cpu_ready_d;
            init_ack_q  <= init_ack_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_ce_n  = ce_n_q;
    assign bus.mem_oe_n  = oe_n_q;
    assign bus.mem_we_n  = we_n_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.init_ack  = init_ack_q;
    assign bus.hex_out   = hex_q;

endmodule

// File: tb/tb_mem_io_sequencer.sv
// Randomized transaction bench: a word-level memory/register model predicts latency, data and strobes.
module tb_mem_io_sequencer;

    localparam int W = 2;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    mem_io_sequencer_if bus ();

    mem_io_sequencer #(.WAIT_CYCLES(W), .IO_ADDR(16'hFFFF)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Board SRAM: 2-state storage so it powers up as zero
    bit [15:0] sram [0:65535];
    always @(posedge Clk) if (!bus.mem_ce_n && !bus.mem_we_n) sram[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = (!bus.mem_ce_n && !bus.mem_oe_n) ? sram[bus.mem_addr] : 16'h0000;

    int checks = 0;
    int errors = 0;

    // Reference model: word memory, read-data holding register, hex register
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] rd_exp  = 16'h0000;
    logic [15:0] hex_exp = 16'h0000;

    logic [15:0] exp_addr  = 16'h0000;
    logic [15:0] exp_wdata = 16'h0000;
    int ce_low_total = 0, we_low_total = 0, bus_bad_total = 0, overlap_total = 0;

    always @(negedge Clk) begin
        if (!bus.mem_ce_n) begin
            ce_low_total++;
            if (bus.mem_addr !== exp_addr) bus_bad_total++;
        end
        if (!bus.mem_we_n) begin
            we_low_total++;
            if (bus.mem_wdata !== exp_wdata) bus_bad_total++;
        end
        if (!bus.mem_we_n && !bus.mem_oe_n) overlap_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic run_txn(input bit is_init, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [9:0] sw);
        bit io   = !is_init && (addr == 16'hFFFF);
        int lat  = 0;
        int wrong = 0;
        int ce0, we0, bad0;
        logic rdy = 1'b0;
        @(negedge Clk);
        bus.sw_in = sw;
        exp_addr  = addr;
        exp_wdata = wdata;
        ce0 = ce_low_total; we0 = we_low_total; bad0 = bus_bad_total;
        if (is_init) begin
            bus.init_req = 1'b1; bus.init_addr = addr; bus.init_wdata = wdata;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
        while (!rdy && lat < 50) begin
            @(negedge Clk);
            lat++;
            rdy = is_init ? bus.init_ack : bus.cpu_ready;
            if (is_init ? bus.cpu_ready : bus.init_ack) wrong++;
            if (!rdy && lat == 1) begin
                // Inputs wander after acceptance; the latched copy must be used
                bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 16'($urandom);
                bus.init_addr = 16'($urandom); bus.init_wdata = 16'($urandom);
            end
        end
        bus.cpu_req = 1'b0;
        bus.init_req = 1'b0;
        if (io) begin
            if (we) hex_exp = wdata; else rd_exp = {6'b0, sw};
        end else if (we || is_init) begin
            ref_mem[addr] = wdata;
        end else begin
            rd_exp = ref_read(addr);
        end
        $display("txn %s we=%0d addr=%h wdata=%h lat=%0d rdata=%h hex=%h",
                 is_init ? "INIT" : "CPU ", we || is_init, addr, wdata, lat, bus.cpu_rdata, bus.hex_out);
        check("latency",   32'(lat), io ? 32'd1 : 32'(W + 2));
        check("cpu_rdata", 32'(bus.cpu_rdata), 32'(rd_exp));
        check("hex_out",   32'(bus.hex_out), 32'(hex_exp));
        check("ce_cycles", 32'(ce_low_total - ce0), io ? 32'd0 : 32'(W + 1));
        check("we_cycles", 32'(we_low_total - we0), (!io && (we || is_init)) ? 32'(W) : 32'd0);
        check("bus_latch", 32'(bus_bad_total - bad0), 32'd0);
        check("wrong_pulse", 32'(wrong), 32'd0);
        @(negedge Clk);
        check("pulse_width", 32'({bus.cpu_ready, bus.init_ack}), 32'd0);
    endtask

    initial begin
        int lat, t_ack, t_rdy, coincide;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.init_req = 0; bus.init_addr = 0; bus.init_wdata = 0; bus.sw_in = 0;

        // Reset held low for two edges
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_strobes", 32'({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}), 32'd7);
        check("rst_hex",     32'(bus.hex_out), 32'd0);
        check("rst_rdata",   32'(bus.cpu_rdata), 32'd0);
        check("rst_pulses",  32'({bus.cpu_ready, bus.init_ack}), 32'd0);
        check("rst_addr",    32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
        Reset = 1'b1;

        // SRAM write then read back, then switch read / hex write
        run_txn(0, 1, 16'h0031, 16'h1234, 10'h000);
        run_txn(0, 0, 16'h0031, 16'h0000, 10'h000);
        check("t2_rdata", 32'(bus.cpu_rdata), 32'h1234);
        run_txn(0, 0, 16'hFFFF, 16'h0000, 10'h003);
        check("t3_sw", 32'(bus.cpu_rdata), 32'h0003);
        run_txn(0, 1, 16'hFFFF, 16'h005A, 10'h003);
        check("t3_hex", 32'(bus.hex_out), 32'h005A);

        // Simultaneous requests: loader first, CPU back-to-back
        @(negedge Clk);
        bus.init_req = 1; bus.init_addr = 16'h0020; bus.init_wdata = 16'hBEEF;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0010;
        exp_addr = 16'h0020; exp_wdata = 16'hBEEF;
        lat = 0; t_ack = 0; t_rdy = 0; coincide = 0;
        while (t_rdy == 0 && lat < 60) begin
            @(negedge Clk);
            lat++;
            if (bus.init_ack && bus.cpu_ready) coincide++;
            if (bus.init_ack && t_ack == 0) begin
                t_ack = lat; bus.init_req = 0; exp_addr = 16'h0010;
            end
            if (bus.cpu_ready) begin
                t_rdy = lat; bus.cpu_req = 0;
            end
        end
        ref_mem[16'h0020] = 16'hBEEF;
        rd_exp = ref_read(16'h0010);
        $display("txn ARB init_ack@%0d cpu_ready@%0d rdata=%h", t_ack, t_rdy, bus.cpu_rdata);
        check("arb_ack_lat", 32'(t_ack), 32'(W + 2));
        check("arb_cpu_lat", 32'(t_rdy - t_ack), 32'(W + 3));
        check("arb_coincide", 32'(coincide), 32'd0);
        check("arb_rdata", 32'(bus.cpu_rdata), 32'(rd_exp));
        run_txn(0, 0, 16'h0020, 16'h0000, 10'h000);

        // Reset in the middle of a CPU write's ACCESS phase
        @(negedge Clk);
        exp_addr = 16'h0050; exp_wdata = 16'hAAAA;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0050; bus.cpu_wdata = 16'hAAAA;
        repeat (2) @(negedge Clk);
        check("mid_we_low", 32'(bus.mem_we_n), 32'd0);
        Reset = 1'b0; bus.cpu_req = 0;
        @(negedge Clk);
        check("mid_strobes", 32'({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}), 32'd7);
        check("mid_no_ready", 32'(bus.cpu_ready), 32'd0);
        @(negedge Clk);
        check("mid_no_ready2", 32'(bus.cpu_ready), 32'd0);
        Reset = 1'b1;
        rd_exp = 16'h0000; hex_exp = 16'h0000;
        $display("txn RESET mid-access rdata=%h hex=%h", bus.cpu_rdata, bus.hex_out);
        check("mid_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("mid_hex", 32'(bus.hex_out), 32'd0);
        run_txn(0, 1, 16'h0031, 16'h4321, 10'h000);
        run_txn(0, 0, 16'h0031, 16'h0000, 10'h000);

        // Randomized mix of requesters, directions and the I/O address
        for (int i = 0; i < 40; i++) begin
            bit ini = ($urandom_range(0, 3) == 0);
            bit wr  = ini ? 1'b1 : 1'($urandom_range(0, 1));
            logic [15:0] a = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
            run_txn(ini, wr, a, 16'($urandom), 10'($urandom));
        end

        check("no_oe_we_overlap", 32'(overlap_total), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
